// File: rtl/serial_4094_driver.sv
// Master for the global 4094 shift-register chain: shifts a parallel word out MSB-first on a
// divided clock, strobes it into the output latches and captures the chain's serial readback.
module serial_4094_driver #(
  parameter int WIDTH         = 24,
  parameter int CLK_DIV       = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             oe,
  output logic             sclk,
  output logic             sdata,
  output logic             strobe,
  input  logic             miso
);

  localparam int PH_MAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int BIT_W  = $clog2(WIDTH) + 1;

  localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  STB_LAST  = PH_W'(STROBE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    STROBE,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] rb_reg, rb_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [BIT_W-1:0] bit_reg, bit_next;
  logic             bit_out_reg, bit_out_next;
  logic             oe_reg, oe_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      rb_reg      <= '0;
      dout_reg    <= '0;
      phase_reg   <= '0;
      bit_reg     <= '0;
      bit_out_reg <= 1'b0;
      oe_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      rb_reg      <= rb_next;
      dout_reg    <= dout_next;
      phase_reg   <= phase_next;
      bit_reg     <= bit_next;
      bit_out_reg <= bit_out_next;
      oe_reg      <= oe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    rb_next      = rb_reg;
    dout_next    = dout_reg;
    phase_next   = phase_reg;
    bit_next     = bit_reg;
    bit_out_next = bit_out_reg;
    oe_next      = oe_reg;

    unique case (state_reg)
      IDLE: begin
        if (din_valid) begin
          shift_next   = din;
          rb_next      = '0;
          bit_next     = BIT_FIRST;
          phase_next   = '0;
          bit_out_next = din[WIDTH-1];
          state_next   = LOW;
        end
      end

      LOW: begin
        if (phase_reg == DIV_LAST) begin
          phase_next = '0;
          state_next = HIGH;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end

      HIGH: begin
        // The data bit is held in bit_out_reg, so shifting early in HIGH never disturbs sdata.
        if (phase_reg == '0) begin
          rb_next    = WIDTH'({rb_reg, miso});
          shift_next = shift_reg << 1;
        end
        if (phase_reg == DIV_LAST) begin
          phase_next = '0;
          if (bit_reg == '0) begin
            state_next = STROBE;
          end else begin
            bit_next     = bit_reg - BIT_W'(1);
            bit_out_next = shift_next[WIDTH-1];
            state_next   = LOW;
          end
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end

      STROBE: begin
        // Readback and oe are committed on entry to DONE so they are visible alongside dout_valid.
        if (phase_reg == STB_LAST) begin
          phase_next = '0;
          dout_next  = rb_reg;
          oe_next    = 1'b1;
          state_next = DONE;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign din_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign dout_valid = (state_reg == DONE);
  assign sclk       = (state_reg == HIGH);
  assign strobe     = (state_reg == STROBE);
  assign sdata      = ((state_reg == LOW) || (state_reg == HIGH)) & bit_out_reg;
  assign dout       = dout_reg;
  assign oe         = oe_reg;

endmodule

// File: tb/tb_serial_4094_driver.sv
// Self-checking bench for serial_4094_driver: a behavioural 4094 chain feeds miso, and every
// transfer's edges, bits, strobe window, completion time and readback are checked against it.
module tb_serial_4094_driver;

  localparam int W = 8;
  localparam int C = 2;
  localparam int S = 2;
  localparam int T_STROBE = 1 + 2 * C * W;
  localparam int T_DONE   = 1 + 2 * C * W + S;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] din, dout;
  logic din_valid, din_ready, dout_valid, busy, oe, sclk, sdata, strobe, miso;

  logic [0:0] d1_din, d1_dout;
  logic d1_valid, d1_ready, d1_dv, d1_busy, d1_oe, d1_sclk, d1_sdata, d1_strobe, d1_miso;

  // Behavioural chain: shifts in the bit presented at each rising sclk once sclk falls again;
  // its last stage drives miso, so a full transfer reads back the previous contents.
  logic [W-1:0] chain, chain_start;
  assign miso = chain[W-1];

  serial_4094_driver #(.WIDTH(W), .CLK_DIV(C), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .oe(oe), .sclk(sclk),
    .sdata(sdata), .strobe(strobe), .miso(miso)
  );

  serial_4094_driver #(.WIDTH(1), .CLK_DIV(1), .STROBE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .din(d1_din), .din_valid(d1_valid), .din_ready(d1_ready),
    .dout(d1_dout), .dout_valid(d1_dv), .busy(d1_busy), .oe(d1_oe), .sclk(d1_sclk),
    .sdata(d1_sdata), .strobe(d1_strobe), .miso(d1_miso)
  );

  int edges, oe_rise, glitch;
  int strobe_cyc[$];
  int dv_cyc[$];
  int accepts[$];
  logic [W-1:0] dv_word[$];
  logic [2*W-1:0] bits_word;
  logic [6:0] snap;
  logic [W-1:0] snap_dout;

  // Drives one scenario from an idle cycle t=0 and records what the pins did, cycle by cycle.
  task automatic observe(input logic [W-1:0] w1, input logic [W-1:0] w2, input int hold,
                         input int pulse_at, input int rst_at, input int ncyc);
    logic prev_sclk, prev_oe, captured;
    repeat (2) @(negedge clk);
    edges = 0; glitch = 0; oe_rise = -1; bits_word = '0; snap = '0; snap_dout = '0;
    strobe_cyc.delete(); dv_cyc.delete(); accepts.delete(); dv_word.delete();
    chain_start = chain;
    prev_sclk = sclk; prev_oe = oe; captured = 1'b0;
    din = w1; din_valid = 1'b1;
    if (din_ready) accepts.push_back(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      din = (accepts.size() > 0) ? w2 : w1;
      din_valid = (k < hold) || (k == pulse_at);
      rst = (k == rst_at);
      if (din_valid && din_ready && !rst) accepts.push_back(k);
      if (sclk && !prev_sclk) begin
        edges++;
        captured = sdata;
        bits_word = {bits_word[2*W-2:0], sdata};
      end
      if (!sclk && prev_sclk) chain = {chain[W-2:0], captured};
      if (strobe) strobe_cyc.push_back(k);
      if (strobe && sclk) glitch++;
      if (dout_valid) begin
        dv_cyc.push_back(k);
        dv_word.push_back(dout);
      end
      if (oe && !prev_oe) oe_rise = k;
      if (rst_at > 0 && k == rst_at + 1) begin
        snap = {sclk, sdata, strobe, oe, din_ready, dout_valid, busy};
        snap_dout = dout;
      end
      prev_sclk = sclk;
      prev_oe = oe;
    end
    din_valid = 1'b0;
    rst = 1'b0;
    $display("xfer w1=%h w2=%h edges=%0d dv=%0d dout0=%h chain=%h", w1, w2, edges,
             dv_cyc.size(), (dv_word.size() > 0) ? dv_word[0] : '0, chain);
  endtask

  task automatic test_reset;
    rst = 1'b1; din = '0; din_valid = 1'b0; d1_din = '0; d1_valid = 1'b0; d1_miso = 1'b0;
    chain = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({din_ready, dout_valid, busy, oe, sclk, sdata, strobe} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", {din_ready, dout_valid, busy, oe, sclk, sdata, strobe}, 7'b1000000);
    end
    total++;
    if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=%h", dout, 8'h00); end
    total++;
    if ({d1_ready, d1_dv, d1_busy, d1_oe, d1_sclk, d1_sdata, d1_strobe} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_w1_flags got=%b want=%b", {d1_ready, d1_dv, d1_busy, d1_oe, d1_sclk, d1_sdata, d1_strobe}, 7'b1000000);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift_pattern;
    chain = W'($urandom);
    observe(8'hA5, 8'hA5, 1, -1, -1, T_DONE + 2);
    total++;
    if (edges !== W) begin bad++; $display("FAIL a5_edges got=%0d want=%0d", edges, W); end
    total++;
    if (bits_word[W-1:0] !== 8'hA5) begin bad++; $display("FAIL a5_bits got=%h want=%h", bits_word[W-1:0], 8'hA5); end
    total++;
    if (strobe_cyc.size() !== S || strobe_cyc[0] !== T_STROBE) begin
      bad++;
      $display("FAIL a5_strobe got=%0d cycles from %0d want=%0d from %0d", strobe_cyc.size(), strobe_cyc[0], S, T_STROBE);
    end
    total++;
    if (dv_cyc.size() !== 1 || dv_cyc[0] !== T_DONE) begin
      bad++;
      $display("FAIL a5_done got=%0d pulses at %0d want=1 at %0d", dv_cyc.size(), dv_cyc[0], T_DONE);
    end
    total++;
    if (oe_rise !== T_DONE) begin bad++; $display("FAIL a5_oe got=%0d want=%0d", oe_rise, T_DONE); end
    total++;
    if (glitch !== 0) begin bad++; $display("FAIL a5_sclk_in_strobe got=%0d want=0", glitch); end
    total++;
    if (dv_word[0] !== chain_start) begin bad++; $display("FAIL a5_readback got=%h want=%h", dv_word[0], chain_start); end
  endtask

  task automatic test_readback;
    chain = 8'h3C;
    observe(8'h00, 8'h00, 1, -1, -1, T_DONE + 2);
    total++;
    if (dv_word[0] !== 8'h3C) begin bad++; $display("FAIL rb_dout got=%h want=%h", dv_word[0], 8'h3C); end
    total++;
    if (chain !== 8'h00) begin bad++; $display("FAIL rb_chain got=%h want=%h", chain, 8'h00); end
    total++;
    if (dout !== 8'h3C) begin bad++; $display("FAIL rb_dout_hold got=%h want=%h", dout, 8'h3C); end
  endtask

  task automatic test_back_to_back;
    chain = W'($urandom);
    observe(8'h11, 8'h22, 1000, -1, -1, 2 * T_DONE + 1);
    total++;
    if (accepts.size() !== 2 || accepts[1] !== T_DONE + 1) begin
      bad++;
      $display("FAIL b2b_accept got=%0d accepts second at %0d want=2 second at %0d", accepts.size(), accepts[1], T_DONE + 1);
    end
    total++;
    if (dv_cyc.size() !== 2 || dv_cyc[0] !== T_DONE || dv_cyc[1] !== 2 * T_DONE + 1) begin
      bad++;
      $display("FAIL b2b_done got=%0d pulses at %0d,%0d want=2 at %0d,%0d", dv_cyc.size(), dv_cyc[0], dv_cyc[1], T_DONE, 2 * T_DONE + 1);
    end
    total++;
    if (edges !== 2 * W) begin bad++; $display("FAIL b2b_edges got=%0d want=%0d", edges, 2 * W); end
    total++;
    if (bits_word !== 16'h1122) begin bad++; $display("FAIL b2b_bits got=%h want=%h", bits_word, 16'h1122); end
    total++;
    if (dv_word[0] !== chain_start || dv_word[1] !== 8'h11) begin
      bad++;
      $display("FAIL b2b_readback got=%h,%h want=%h,%h", dv_word[0], dv_word[1], chain_start, 8'h11);
    end
  endtask

  task automatic test_ignore_valid;
    chain = W'($urandom);
    // cycle 19 is the first HIGH cycle while the bit counter holds 3
    observe(8'h96, 8'h69, 1, 1 + 2 * C * 4 + C, -1, T_DONE + 4);
    total++;
    if (edges !== W || accepts.size() !== 1) begin
      bad++;
      $display("FAIL ign_edges got=%0d edges %0d accepts want=%0d edges 1 accept", edges, accepts.size(), W);
    end
    total++;
    if (bits_word[W-1:0] !== 8'h96 || dv_cyc.size() !== 1) begin
      bad++;
      $display("FAIL ign_bits got=%h with %0d pulses want=%h with 1", bits_word[W-1:0], dv_cyc.size(), 8'h96);
    end
    total++;
    if (dv_word[0] !== chain_start) begin bad++; $display("FAIL ign_readback got=%h want=%h", dv_word[0], chain_start); end
  endtask

  task automatic test_reset_abort;
    chain = W'($urandom);
    // the fourth rising sclk lands in cycle 15; rst is driven during cycle 16
    observe(8'h5A, 8'h5A, 1, -1, 1 + 2 * C * 3 + C + 1, 20);
    total++;
    if (snap !== 7'b0000100) begin bad++; $display("FAIL abort_flags got=%b want=%b", snap, 7'b0000100); end
    total++;
    if (snap_dout !== '0) begin bad++; $display("FAIL abort_dout got=%h want=%h", snap_dout, 8'h00); end
    total++;
    if (edges !== 4 || dv_cyc.size() !== 0) begin
      bad++;
      $display("FAIL abort_edges got=%0d edges %0d pulses want=4 edges 0 pulses", edges, dv_cyc.size());
    end
    observe(8'hFF, 8'hFF, 1, -1, -1, T_DONE + 2);
    total++;
    if (edges !== W || bits_word[W-1:0] !== 8'hFF) begin
      bad++;
      $display("FAIL after_abort_bits got=%0d edges %h want=%0d edges %h", edges, bits_word[W-1:0], W, 8'hFF);
    end
    total++;
    if (dv_cyc.size() !== 1 || dv_cyc[0] !== T_DONE || oe_rise !== T_DONE) begin
      bad++;
      $display("FAIL after_abort_done got=%0d pulses at %0d oe at %0d want=1 at %0d", dv_cyc.size(), dv_cyc[0], oe_rise, T_DONE);
    end
    total++;
    if (dv_word[0] !== chain_start) begin bad++; $display("FAIL after_abort_readback got=%h want=%h", dv_word[0], chain_start); end
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    for (int i = 0; i < 6; i++) begin
      chain = W'($urandom);
      w = W'($urandom);
      observe(w, w, 1, -1, -1, T_DONE + 2);
      total++;
      if (bits_word[W-1:0] !== w || edges !== W) begin
        bad++;
        $display("FAIL rand_bits[%0d] got=%h edges %0d want=%h edges %0d", i, bits_word[W-1:0], edges, w, W);
      end
      total++;
      if (dv_word[0] !== chain_start || dv_cyc[0] !== T_DONE) begin
        bad++;
        $display("FAIL rand_readback[%0d] got=%h at %0d want=%h at %0d", i, dv_word[0], dv_cyc[0], chain_start, T_DONE);
      end
      total++;
      if (chain !== w) begin bad++; $display("FAIL rand_chain[%0d] got=%h want=%h", i, chain, w); end
    end
  endtask

  task automatic test_width1;
    int e1, dv1, stb1;
    logic bit1, rb1, m;
    e1 = 0; dv1 = -1; stb1 = -1; bit1 = 1'b0; rb1 = 1'b0;
    m = 1'($urandom);
    @(negedge clk);
    d1_din = 1'b1; d1_valid = 1'b1; d1_miso = m;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d1_valid = 1'b0;
      if (d1_sclk) begin e1++; bit1 = d1_sdata; end
      if (d1_strobe && stb1 < 0) stb1 = k;
      if (d1_dv) begin dv1 = k; rb1 = d1_dout[0]; end
    end
    $display("xfer w1 din=1 edges=%0d done=%0d dout=%b", e1, dv1, rb1);
    total++;
    if (e1 !== 1 || bit1 !== 1'b1) begin bad++; $display("FAIL w1_edges got=%0d bit %b want=1 bit 1", e1, bit1); end
    total++;
    if (stb1 !== 3 || dv1 !== 4) begin bad++; $display("FAIL w1_timing got=strobe %0d done %0d want=strobe 3 done 4", stb1, dv1); end
    total++;
    if (rb1 !== m) begin bad++; $display("FAIL w1_readback got=%b want=%b", rb1, m); end
  endtask

  initial begin
    test_reset();
    test_shift_pattern();
    test_readback();
    test_back_to_back();
    test_ignore_valid();
    test_reset_abort();
    test_random();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_4094_driver.md
Name: serial_4094_driver

Overview:
FPGA-side master for the global 4094 shift-register chain. It is the stage that drives the GLB_4094_CLK/DATA/STROBE pins and enables GLB_4094_OE without the MCU bit-banging them through the SPI mux.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out MSB-first at a divided rate and pulses the strobe to latch it.
- Captures the chain's serial readback (GLB_4094_MISO_CTL) into a parallel word.
- Its pin-level outputs feed the SPI mux vec_cs/vec_clk/vec_mosi lanes, or the pins directly.

Parameters:
- WIDTH, 24, bits per transfer (3 cascaded 4094s); must be >= 1.
- CLK_DIV, 4, clk cycles per half-period of the 4094 clock; must be >= 1.
- STROBE_CYCLES, 2, clk cycles the strobe is held high; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  word to load into the chain; sent MSB first.
- din_valid  in  1  din is valid.
- din_ready  out  1  block is idle and can accept din.
- dout  out  WIDTH  readback word from the most recent transfer.
- dout_valid  out  1  one-cycle pulse when a transfer completes.
- busy  out  1  transfer in progress.
- oe  out  1  to GLB_4094_OE; goes high after the first completed transfer.
- sclk  out  1  to GLB_4094_CLK.
- sdata  out  1  to GLB_4094_DATA.
- strobe  out  1  to GLB_4094_STROBE_CTL; active high.
- miso  in  1  from GLB_4094_MISO_CTL.

Behaviour:
- Reset values: din_ready=1; dout=0; dout_valid=0; busy=0; oe=0; sclk=0; sdata=0; strobe=0; all counters=0; state=IDLE.
  - rst asserted mid-transfer aborts immediately to these values on the next edge.
  - oe drops to 0, so 4094 outputs are disabled until a full transfer completes again.
- States: IDLE, LOW, HIGH, STROBE, DONE.
- IDLE:
  - din_ready=1, busy=0.
  - On din_valid=1 (accept cycle t): latch din into the shift register, set bit counter to WIDTH-1, go to LOW.
  - din_ready=0 from t+1 onward.
- LOW, for CLK_DIV cycles:
  - sclk=0; sdata = current MSB of the shift register, stable for the whole phase; then go to HIGH.
- HIGH, for CLK_DIV cycles:
  - sclk=1.
  - On the first HIGH cycle, sample miso into the LSB of the readback register (shifting left) and shift the output register left by one.
  - At the end of the phase: if bit counter is 0, go to STROBE; otherwise decrement and go to LOW.
- STROBE, for STROBE_CYCLES cycles: sclk=0, sdata=0, strobe=1.
- DONE, 1 cycle:
  - strobe=0; dout <= readback register; dout_valid=1; oe <= 1 (sticky until rst).
  - Next cycle: IDLE.
- Timing:
  - The first LOW cycle is t+1. DONE is cycle t+1+2*CLK_DIV*WIDTH+STROBE_CYCLES.
  - din_ready=1 again the cycle after DONE, so back-to-back words have a one-cycle gap.
- busy=1 in every state except IDLE.
- din_valid outside IDLE is ignored; the word is not queued.
- dout holds its value between transfers and changes only in DONE.
- Exactly WIDTH rising sclk edges per transfer.
- sclk is 0 whenever strobe=1, and strobe=1 only in STROBE.

Test Plan:
Bench settings: WIDTH=8, CLK_DIV=2, STROBE_CYCLES=2.
1. Reset, then din=0xA5 with valid at t -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; strobe high at t+33..t+34; dout_valid at t+35; oe 0->1 at t+35.
2. Bench 4094 model preloaded with 0x3C drives miso; send 0x00 -> dout=0x3C at DONE; the model then holds 0x00.
3. din_valid held high with din=0x11 then 0x22 -> second accept at t+36; dout_valid at t+35 and t+71; no extra sclk edges.
4. Pulse din_valid during HIGH of bit 3 -> ignored; only 8 edges; dout from the original transfer only.
5. rst asserted after 4 sclk edges -> next cycle sclk=0, sdata=0, strobe=0, oe=0, din_ready=1, no dout_valid; a new 0xFF transfer then completes normally.
6. WIDTH=1, CLK_DIV=1, STROBE_CYCLES=1, din=1 -> one sclk edge, DONE at t+4.
